// File: rtl/demux_rr_scheduler_if.sv
// Producer/consumer bundle for the round-robin demux scheduler.
// The slave modport is the scheduler side; master is the environment side.
interface demux_rr_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_CH-1:0]        en_mask;
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [SEL_W-1:0]         cur_sel;
    logic                     busy;

    modport slave (
        input  en_mask,
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output cur_sel,
        output busy
    );

    modport master (
        output en_mask,
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  cur_sel,
        input  busy
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for a 1xN demux: one-word buffer, fair rotation
// over the enabled channels, word held until its channel accepts it.
module demux_rr_scheduler #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input logic                clk,
    input logic                rst_n,
    demux_rr_scheduler_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [SEL_W-1:0]    w_rr_ptr_nxt;
    logic [SEL_W-1:0]    r_cur_sel;
    logic [SEL_W-1:0]    w_cur_sel_nxt;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   w_buf_nxt;
    logic [SEL_W-1:0]    w_base;
    logic [SEL_W-1:0]    w_target;
    logic                w_any_en;
    logic                w_deliver;
    logic                w_in_ready;
    logic                w_accept;

    assign w_any_en   = |bus.en_mask;
    assign w_deliver  = (r_state == S_HOLD) && bus.out_ready[r_cur_sel];
    assign w_in_ready = w_any_en &&
                        ((r_state == S_IDLE) || bus.out_ready[r_cur_sel]);
    assign w_accept   = bus.in_valid && w_in_ready;

    // A back-to-back accept searches from the pointer as it will be
    // after this delivery, so rotation stays fair under full throughput.
    assign w_base = w_deliver ? (r_cur_sel + SEL_W'(1)) : r_rr_ptr;

    always_comb begin : target_search
        logic [SEL_W-1:0] idx;
        w_target = '0;
        idx      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = w_base + SEL_W'(k);
            if (bus.en_mask[idx]) begin
                w_target = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_cur_sel <= '0;
            r_buf     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_buf     <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cur_sel_nxt = r_cur_sel;
        w_buf_nxt     = r_buf;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_buf_nxt     = bus.in_data;
                    w_cur_sel_nxt = w_target;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_deliver) begin
                    w_rr_ptr_nxt = r_cur_sel + SEL_W'(1);
                    if (w_accept) begin
                        w_buf_nxt     = bus.in_data;
                        w_cur_sel_nxt = w_target;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Demux decode: only the targeted lane carries the word, others read 0.
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((r_state == S_HOLD) && (r_cur_sel == SEL_W'(i))) begin
                bus.out_valid[i]                = 1'b1;
                bus.out_data[i*DATA_W +: DATA_W] = r_buf;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.cur_sel  = r_cur_sel;
    assign bus.busy     = (r_state == S_HOLD);

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Round-robin scheduler/controller for a 1xN demultiplexer datapath.
- Accepts a single valid/ready input stream and routes each word to exactly one enabled output channel.
- Rotates fairly across channels enabled in a runtime mask; holds each word until the selected channel accepts it.
- Sits between a single producer and N consumer lanes; it is the sequencing layer for the demux trees used elsewhere in the design.

Parameters:
DATA_W, 8, width of each data word
NUM_CH, 4, number of output channels; legal values 2, 4 or 8
SEL_W, 2, select width; must equal log2(NUM_CH)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
en_mask  input  NUM_CH  channel enable; bit i=1 makes channel i eligible
in_data  input  DATA_W  input word
in_valid  input  1  input word present
in_ready  output  1  scheduler can accept a word this cycle
out_data  output  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
out_valid  output  NUM_CH  one-hot or zero; channel i holds a word
out_ready  input  NUM_CH  channel i accepts its word
cur_sel  output  SEL_W  index of the channel currently targeted (held word)
busy  output  1  a word is held (state HOLD)

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0, cur_sel=0, buffer=0.
  - All out_valid=0, all out_data=0, busy=0.
  - Any held word is discarded, including on reset mid-HOLD.
- States: IDLE (buffer empty) and HOLD (buffer full, target fixed).
- Target select (combinational, evaluated at acceptance):
  - Lowest index j in rr_ptr, rr_ptr+1, ... (mod NUM_CH) with en_mask[j]=1.
  - Uses en_mask as sampled in the acceptance cycle.
- in_ready = (en_mask != 0) && (state==IDLE || out_ready[cur_sel]).
  - With en_mask==0, in_ready=0 and nothing is accepted.
- Accept = in_valid && in_ready. On accept: buffer<=in_data, cur_sel<=target, state<=HOLD.
- In HOLD:
  - out_valid[cur_sel]=1; all other out_valid bits are 0.
  - out_data lane cur_sel = buffer; all other lanes = 0 (demux semantics).
- Delivery = HOLD && out_ready[cur_sel]. On delivery: rr_ptr <= (cur_sel+1) mod NUM_CH.
  - No simultaneous accept: state<=IDLE.
  - Simultaneous accept (back-to-back): new word loaded and state stays HOLD. The new target is computed from the updated pointer, i.e. the search starts at cur_sel+1.
- Latency: word accepted at edge N appears with out_valid at cycle N+1. Sustained throughput is 1 word/cycle when the consumer is always ready.
- Boundary conditions:
  - en_mask changes during HOLD: no effect on the held word; it stays on cur_sel even if that channel is now disabled.
  - out_ready on non-target channels is ignored.
  - rr_ptr wraps from NUM_CH-1 to 0.
  - Single enabled channel: every word goes to that channel.
  - in_valid dropped while in_ready=0 is legal; the scheduler never captures without accept.
  - out_valid/out_data are stable while out_ready[cur_sel]=0.
- Outputs other than in_ready are registered or decoded purely from state and buffer. in_ready has a combinational path from out_ready and en_mask.

Test Plan:
- Reset + fairness: rst_n low then high, en_mask=4'b1111, all out_ready=1, stream 0x11,0x22,0x33,0x44,0x55 -> delivered on channels 0,1,2,3,0; out_valid at 1 cycle after each accept; back-to-back, in_ready stays 1.
- Masked skip: en_mask=4'b1010, stream 0xA0,0xA1,0xA2 -> channels 1,3,1; out_valid[0] and out_valid[2] never assert; lanes 0/2 out_data=0.
- Backpressure: accept 0x5C to ch0, hold out_ready[0]=0 for 5 cycles -> out_valid[0]=1, out_data lane0=0x5C stable, in_ready=0, busy=1; release -> delivered, next word targets ch1.
- Mask change mid-HOLD / empty mask: word held on ch2, set en_mask=0 -> word still delivered on ch2; afterwards in_ready=0 with in_valid=1; restore en_mask=4'b0001 -> next word goes to ch0.
- Reset mid-operation: word 0x7E held on ch3 with out_ready=0, pulse rst_n low asynchronously (between edges) -> immediately out_valid=0, busy=0, cur_sel=0; after release, first word goes to ch0.
